// File: rtl/filter_hs_adapter.sv
// filter_hs_adapter
//   Bridges valid/ready sample streams to the four-phase req/ack ports of the
//   FIR filter, all in the filter's clock domain.
//   TX: upstream samples are buffered in a small FIFO. Each sample is then
//       offered to the filter input as a four-phase transfer.
//   RX: four-phase transfers from the filter output are acknowledged and
//       re-emitted downstream as a valid/ready stream.
//
// Ports
//   clk_i, rst_i            clock; synchronous active-high reset
//   s_data_i/s_valid_i      upstream sample stream in
//   s_ready_o               upstream ready (!full, held 0 while rst_i)
//   hs_data_o/hs_req_o      four-phase request into the filter input
//   hs_ack_i                four-phase ack from the filter input
//   hs_data_i/hs_req_i      four-phase request from the filter output
//   hs_ack_o                four-phase ack to the filter output
//   m_data_o/m_valid_o      downstream sample stream out
//   m_ready_i               downstream ready
//   tx_level_o              TX FIFO occupancy
//   proto_err_o             sticky protocol-violation flag
module filter_hs_adapter #(
  parameter int DataWidth = 18,
  parameter int FifoDepth = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [DataWidth-1:0]           s_data_i,
  input  logic                           s_valid_i,
  output logic                           s_ready_o,
  output logic [DataWidth-1:0]           hs_data_o,
  output logic                           hs_req_o,
  input  logic                           hs_ack_i,
  input  logic [DataWidth-1:0]           hs_data_i,
  input  logic                           hs_req_i,
  output logic                           hs_ack_o,
  output logic [DataWidth-1:0]           m_data_o,
  output logic                           m_valid_o,
  input  logic                           m_ready_i,
  output logic [$clog2(FifoDepth+1)-1:0] tx_level_o,
  output logic                           proto_err_o
);

  localparam int PtrW = $clog2(FifoDepth);
  localparam int LvlW = $clog2(FifoDepth + 1);

  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_REL} tx_state_t;
  typedef enum logic       {RX_IDLE, RX_ACK}         rx_state_t;

  // TX FIFO
  logic [DataWidth-1:0] r_mem [FifoDepth];
  logic [PtrW-1:0]      r_wr_ptr;
  logic [PtrW-1:0]      r_rd_ptr;
  logic [LvlW-1:0]      r_level;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;

  // TX handshake
  tx_state_t            r_tx_state;
  tx_state_t            w_tx_next;
  logic                 r_hs_req;
  logic [DataWidth-1:0] r_hs_data;

  // RX handshake
  rx_state_t            r_rx_state;
  rx_state_t            w_rx_next;
  logic                 w_rx_cap;
  logic                 r_m_valid;
  logic [DataWidth-1:0] r_m_data;
  logic                 r_hs_req_d;
  logic                 r_proto_err;
  logic                 w_proto_viol;

  assign w_full  = (r_level == LvlW'(FifoDepth));
  assign w_empty = (r_level == '0);
  // Ready is masked during reset so nothing is accepted into a FIFO being flushed.
  assign s_ready_o = !w_full && !rst_i;
  assign w_push    = s_valid_i && s_ready_o;
  assign w_pop     = (r_tx_state == TX_IDLE) && !w_empty;

  // Storage carries data only; occupancy and pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LvlW'(1);
        2'b01:   r_level <= r_level - LvlW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE: if (!w_empty) w_tx_next = TX_REQ;
      TX_REQ:  if (hs_ack_i) w_tx_next = TX_REL;
      TX_REL:  if (!hs_ack_i) w_tx_next = TX_IDLE;
      default: w_tx_next = TX_IDLE;
    endcase
  end

  // req is registered off the TX_REQ state, so it rises one edge after the
  // pop, and it drops on the same edge that sees ack so that req never
  // lingers high once the filter has answered (a 1-cycle ack stays legal).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tx_state <= TX_IDLE;
      r_hs_req   <= 1'b0;
      r_hs_data  <= '0;
    end else begin
      r_tx_state <= w_tx_next;
      r_hs_req   <= (r_tx_state == TX_REQ) && !hs_ack_i;
      if (w_pop) r_hs_data <= r_mem[r_rd_ptr];
    end
  end

  // Capture only when the output register is free or being drained this cycle;
  // otherwise the ack is withheld, which back-pressures the filter.
  assign w_rx_cap = (r_rx_state == RX_IDLE) && hs_req_i && (!r_m_valid || m_ready_i);

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE: if (w_rx_cap)  w_rx_next = RX_ACK;
      RX_ACK:  if (!hs_req_i) w_rx_next = RX_IDLE;
      default: w_rx_next = RX_IDLE;
    endcase
  end

  // Violations: ack with no outstanding req, or a req dropped before it was acked.
  assign w_proto_viol = ((r_tx_state == TX_IDLE) && hs_ack_i) ||
                        ((r_rx_state == RX_IDLE) && r_hs_req_d && !hs_req_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_state  <= RX_IDLE;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_hs_req_d  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      r_hs_req_d <= hs_req_i;
      if (w_rx_cap) begin
        r_m_valid <= 1'b1;
        r_m_data  <= hs_data_i;
      end else if (m_ready_i) begin
        r_m_valid <= 1'b0;
      end
      if (w_proto_viol) r_proto_err <= 1'b1;
    end
  end

  assign hs_req_o    = r_hs_req;
  assign hs_data_o   = r_hs_data;
  assign hs_ack_o    = (r_rx_state == RX_ACK);
  assign m_valid_o   = r_m_valid;
  assign m_data_o    = r_m_data;
  assign tx_level_o  = r_level;
  assign proto_err_o = r_proto_err;

endmodule

// File: tb/tb_filter_hs_adapter.sv
module tb_filter_hs_adapter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [17:0] s_data_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [17:0] hs_data_o;
  logic        hs_req_o;
  logic        hs_ack_i;
  logic [17:0] hs_data_i;
  logic        hs_req_i;
  logic        hs_ack_o;
  logic [17:0] m_data_o;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [2:0]  tx_level_o;
  logic        proto_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [17:0] b [6];

  filter_hs_adapter #(.DataWidth(18), .FifoDepth(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .s_data_i    (s_data_i),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_o),
    .hs_data_o   (hs_data_o),
    .hs_req_o    (hs_req_o),
    .hs_ack_i    (hs_ack_i),
    .hs_data_i   (hs_data_i),
    .hs_req_i    (hs_req_i),
    .hs_ack_o    (hs_ack_o),
    .m_data_o    (m_data_o),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .tx_level_o  (tx_level_o),
    .proto_err_o (proto_err_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Filter-input responder: wait (bounded) for req, check the offered sample,
  // ack for one cycle, and confirm req is down in the cycle after the ack.
  task automatic tx_ack_one(input string tag, input logic [17:0] exp_data);
    int n = 0;
    while (!hs_req_o && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_req_seen"}, {31'd0, hs_req_o}, 32'd1);
    chk({tag, "_data"}, {14'd0, hs_data_o}, {14'd0, exp_data});
    hs_ack_i = 1'b1;
    step();
    chk({tag, "_req_low"}, {31'd0, hs_req_o}, 32'd0);
    hs_ack_i = 1'b0;
    step();
  endtask

  initial begin
    b[0] = 18'h0B000; b[1] = 18'h0B001; b[2] = 18'h0B002;
    b[3] = 18'h0B003; b[4] = 18'h0B004; b[5] = 18'h0B005;

    rst_i = 1'b1; s_valid_i = 1'b1; s_data_i = 18'h00011;
    hs_ack_i = 1'b0; hs_data_i = '0; hs_req_i = 1'b0; m_ready_i = 1'b0;

    // Reset held 3 cycles with upstream valid
    step(); step(); step();
    chk("rst_s_ready",  {31'd0, s_ready_o}, 32'd0);
    chk("rst_hs_req",   {31'd0, hs_req_o}, 32'd0);
    chk("rst_hs_ack",   {31'd0, hs_ack_o}, 32'd0);
    chk("rst_hs_data",  {14'd0, hs_data_o}, 32'd0);
    chk("rst_m_valid",  {31'd0, m_valid_o}, 32'd0);
    chk("rst_m_data",   {14'd0, m_data_o}, 32'd0);
    chk("rst_level",    {29'd0, tx_level_o}, 32'd0);
    chk("rst_proto",    {31'd0, proto_err_o}, 32'd0);

    rst_i = 1'b0; s_valid_i = 1'b0;
    step();
    chk("post_rst_ready", {31'd0, s_ready_o}, 32'd1);
    chk("post_rst_level", {29'd0, tx_level_o}, 32'd0);

    // Single sample: push at edge t, req after t+2, ack two cycles later
    s_valid_i = 1'b1; s_data_i = 18'h00123;
    step();
    s_valid_i = 1'b0;
    chk("t2_level_t",   {29'd0, tx_level_o}, 32'd1);
    chk("t2_req_t",     {31'd0, hs_req_o}, 32'd0);
    step();
    chk("t2_req_t1",    {31'd0, hs_req_o}, 32'd0);
    chk("t2_level_t1",  {29'd0, tx_level_o}, 32'd0);
    step();
    chk("t2_req_t2",    {31'd0, hs_req_o}, 32'd1);
    chk("t2_data_t2",   {14'd0, hs_data_o}, 32'h00123);
    step();
    chk("t2_req_hold",  {31'd0, hs_req_o}, 32'd1);
    hs_ack_i = 1'b1;
    step();
    chk("t2_req_after_ack", {31'd0, hs_req_o}, 32'd0);
    chk("t2_data_stable",   {14'd0, hs_data_o}, 32'h00123);
    hs_ack_i = 1'b0;
    step();
    chk("t2_req_idle",  {31'd0, hs_req_o}, 32'd0);
    chk("t2_proto",     {31'd0, proto_err_o}, 32'd0);

    // Back-to-back pushes with ack stuck low: b[0] parks in the TX slot,
    // b[1..4] fill the FIFO, b[5] must wait for a drain
    for (int i = 0; i < 5; i++) begin
      s_valid_i = 1'b1; s_data_i = b[i];
      step();
    end
    chk("t3_level_full", {29'd0, tx_level_o}, 32'd4);
    chk("t3_ready_full", {31'd0, s_ready_o}, 32'd0);
    s_data_i = b[5];
    step(); step();
    chk("t3_level_held", {29'd0, tx_level_o}, 32'd4);
    chk("t3_ready_held", {31'd0, s_ready_o}, 32'd0);
    chk("t3_req_b0",     {31'd0, hs_req_o}, 32'd1);
    s_valid_i = 1'b0;
    tx_ack_one("t3_b0", b[0]);
    begin
      int n = 0;
      while (!s_ready_o && n < 20) begin
        step();
        n++;
      end
    end
    chk("t3_ready_drain", {31'd0, s_ready_o}, 32'd1);
    s_valid_i = 1'b1; s_data_i = b[5];
    step();
    s_valid_i = 1'b0;
    chk("t3_level_b5", {29'd0, tx_level_o}, 32'd4);
    tx_ack_one("t3_b1", b[1]);
    tx_ack_one("t3_b2", b[2]);
    tx_ack_one("t3_b3", b[3]);
    tx_ack_one("t3_b4", b[4]);
    tx_ack_one("t3_b5", b[5]);
    chk("t3_level_empty", {29'd0, tx_level_o}, 32'd0);
    chk("t3_proto",       {31'd0, proto_err_o}, 32'd0);

    // RX: fill the output register first, then stall a 0x3FFFF request
    hs_req_i = 1'b1; hs_data_i = 18'h00055; m_ready_i = 1'b0;
    step();
    chk("t4_first_ack",   {31'd0, hs_ack_o}, 32'd1);
    chk("t4_first_valid", {31'd0, m_valid_o}, 32'd1);
    chk("t4_first_data",  {14'd0, m_data_o}, 32'h00055);
    hs_req_i = 1'b0;
    step();
    chk("t4_ack_rel", {31'd0, hs_ack_o}, 32'd0);
    hs_req_i = 1'b1; hs_data_i = 18'h3FFFF;
    step(); step();
    chk("t4_stall_ack",   {31'd0, hs_ack_o}, 32'd0);
    chk("t4_stall_data",  {14'd0, m_data_o}, 32'h00055);
    chk("t4_stall_valid", {31'd0, m_valid_o}, 32'd1);
    m_ready_i = 1'b1;
    step();
    chk("t4_ack_go",   {31'd0, hs_ack_o}, 32'd1);
    chk("t4_max_data", {14'd0, m_data_o}, 32'h3FFFF);
    chk("t4_valid_kept", {31'd0, m_valid_o}, 32'd1);
    hs_req_i = 1'b0;
    step();
    chk("t4_drained", {31'd0, m_valid_o}, 32'd0);
    chk("t4_ack_idle", {31'd0, hs_ack_o}, 32'd0);
    m_ready_i = 1'b0;
    chk("t4_proto", {31'd0, proto_err_o}, 32'd0);

    // Ack without req while TX is idle
    hs_ack_i = 1'b1;
    step();
    hs_ack_i = 1'b0;
    chk("t5_proto_set", {31'd0, proto_err_o}, 32'd1);
    step(); step(); step();
    chk("t5_proto_sticky", {31'd0, proto_err_o}, 32'd1);

    // Reset while TX_REQ with two entries queued
    for (int i = 0; i < 3; i++) begin
      s_valid_i = 1'b1; s_data_i = 18'h0C000 + 18'(i);
      step();
    end
    s_valid_i = 1'b0;
    chk("t6_req_before", {31'd0, hs_req_o}, 32'd1);
    chk("t6_level_before", {29'd0, tx_level_o}, 32'd2);
    rst_i = 1'b1;
    step();
    chk("t6_req_rst",   {31'd0, hs_req_o}, 32'd0);
    chk("t6_level_rst", {29'd0, tx_level_o}, 32'd0);
    chk("t6_proto_rst", {31'd0, proto_err_o}, 32'd0);
    chk("t6_ready_rst", {31'd0, s_ready_o}, 32'd0);
    rst_i = 1'b0;
    step(); step(); step(); step(); step();
    chk("t6_no_req", {31'd0, hs_req_o}, 32'd0);
    chk("t6_level_after", {29'd0, tx_level_o}, 32'd0);

    // Filter withdraws a stalled req before it is acked
    hs_req_i = 1'b1; hs_data_i = 18'h00001; m_ready_i = 1'b0;
    step();
    chk("t7_cap_ack", {31'd0, hs_ack_o}, 32'd1);
    hs_req_i = 1'b0;
    step();
    hs_req_i = 1'b1; hs_data_i = 18'h00002;
    step();
    chk("t7_stall_ack", {31'd0, hs_ack_o}, 32'd0);
    chk("t7_proto_clear", {31'd0, proto_err_o}, 32'd0);
    hs_req_i = 1'b0;
    step();
    chk("t7_proto_withdraw", {31'd0, proto_err_o}, 32'd1);
    chk("t7_data_kept", {14'd0, m_data_o}, 32'h00001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
